// File: rtl/face_window_loader.sv
// Avalon-MM initiator that copies an integral-image window into the face-detection
// accelerator, starts it, polls for completion, reads the verdict and stops it again.
module face_window_loader #(
    parameter int NUM_WORDS  = 400,
    parameter int START_ADDR = 509,
    parameter int DONE_ADDR  = 510,
    parameter int FACE_ADDR  = 511,
    parameter int POLL_GAP   = 4,
    parameter int MAX_POLLS  = 1024
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        START,
    output logic        BUSY,
    output logic        DONE,
    output logic [31:0] IS_FACE,
    output logic        TIMEOUT_ERR,
    output logic        SRC_RD,
    output logic [8:0]  SRC_ADDR,
    input  logic [31:0] SRC_DATA,
    output logic        AVM_CS,
    output logic        AVM_READ,
    output logic        AVM_WRITE,
    output logic [3:0]  AVM_BYTE_EN,
    output logic [8:0]  AVM_ADDR,
    output logic [31:0] AVM_WRITEDATA,
    input  logic [31:0] AVM_READDATA,
    input  logic        AVM_WAITREQUEST
);

    localparam int PCW = $clog2(MAX_POLLS + 1);
    localparam int GCW = $clog2(POLL_GAP + 1);

    localparam logic [8:0]     IDX_LAST = 9'(NUM_WORDS - 1);
    localparam logic [8:0]     A_START  = 9'(START_ADDR);
    localparam logic [8:0]     A_DONE   = 9'(DONE_ADDR);
    localparam logic [8:0]     A_FACE   = 9'(FACE_ADDR);
    localparam logic [PCW-1:0] POLL_MAX = PCW'(MAX_POLLS);
    localparam logic [GCW-1:0] GAP_LAST = GCW'(POLL_GAP - 1);

    typedef enum logic [3:0] {
        IDLE, CLR_DONE, FETCH, WR_DATA, WR_START,
        POLL_RD, POLL_WAIT, RD_FACE, WR_STOP, FINISH
    } state_t;

    state_t          state, state_d;
    logic [8:0]      idx, idx_d;
    logic [PCW-1:0]  polls, polls_d;
    logic [GCW-1:0]  gap, gap_d;
    logic            tmo, tmo_d;
    logic            fresh, fresh_d;
    logic [31:0]     wdata_hold, wdata_d;
    logic [31:0]     face_d;
    logic            terr_d, busy_d, done_d;
    logic            cs_d, read_d, write_d, src_rd_d;
    logic [8:0]      addr_d, src_addr_d;
    logic            xfer;

    assign xfer        = AVM_CS && !AVM_WAITREQUEST;
    assign AVM_BYTE_EN = {4{AVM_CS}};
    // Source RAM data is only valid in the first WR_DATA cycle; a stalled write replays the held copy.
    assign AVM_WRITEDATA = fresh ? SRC_DATA : wdata_hold;

    always_comb begin
        state_d = state;
        idx_d   = idx;
        polls_d = polls;
        gap_d   = gap;
        tmo_d   = tmo;
        face_d  = IS_FACE;
        terr_d  = TIMEOUT_ERR;
        busy_d  = BUSY;
        case (state)
            IDLE: begin
                if (START) begin
                    state_d = CLR_DONE;
                    idx_d   = '0;
                    tmo_d   = 1'b0;
                    face_d  = '0;
                    terr_d  = 1'b0;
                    busy_d  = 1'b1;
                end
            end
            CLR_DONE: if (xfer) state_d = FETCH;
            FETCH:    state_d = WR_DATA;
            WR_DATA: begin
                if (xfer) begin
                    if (idx == IDX_LAST) begin
                        state_d = WR_START;
                    end else begin
                        idx_d   = idx + 9'd1;
                        state_d = FETCH;
                    end
                end
            end
            WR_START: begin
                if (xfer) begin
                    state_d = POLL_RD;
                    polls_d = '0;
                end
            end
            POLL_RD: begin
                if (xfer) begin
                    if (AVM_READDATA[15:0] != 16'd0) begin
                        state_d = RD_FACE;
                    end else begin
                        polls_d = polls + PCW'(1);
                        if (polls + PCW'(1) == POLL_MAX) begin
                            state_d = WR_STOP;
                            tmo_d   = 1'b1;
                        end else begin
                            state_d = POLL_WAIT;
                            gap_d   = '0;
                        end
                    end
                end
            end
            POLL_WAIT: begin
                if (gap == GAP_LAST) state_d = POLL_RD;
                else                 gap_d   = gap + GCW'(1);
            end
            RD_FACE: begin
                if (xfer) begin
                    face_d  = AVM_READDATA;
                    state_d = WR_STOP;
                end
            end
            WR_STOP: begin
                if (xfer) begin
                    state_d = FINISH;
                    busy_d  = 1'b0;
                    terr_d  = tmo;
                end
            end
            FINISH:  state_d = IDLE;
            default: state_d = IDLE;
        endcase

        // Bus and source strobes are registered, so they are decoded from the next state.
        done_d     = (state_d == FINISH);
        src_rd_d   = (state_d == FETCH);
        src_addr_d = (state_d == FETCH) ? idx_d : 9'd0;
        read_d     = (state_d == POLL_RD) || (state_d == RD_FACE);
        write_d    = (state_d == CLR_DONE) || (state_d == WR_DATA) ||
                     (state_d == WR_START) || (state_d == WR_STOP);
        cs_d       = read_d || write_d;
        fresh_d    = (state_d == WR_DATA) && (state == FETCH);
        case (state_d)
            CLR_DONE, POLL_RD: addr_d = A_DONE;
            WR_DATA:           addr_d = idx_d;
            WR_START, WR_STOP: addr_d = A_START;
            RD_FACE:           addr_d = A_FACE;
            default:           addr_d = 9'd0;
        endcase
        case (state_d)
            WR_START: wdata_d = 32'd1;
            WR_DATA:  wdata_d = AVM_WRITEDATA;
            default:  wdata_d = 32'd0;
        endcase
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state       <= IDLE;
            idx         <= '0;
            polls       <= '0;
            gap         <= '0;
            tmo         <= 1'b0;
            fresh       <= 1'b0;
            wdata_hold  <= '0;
            BUSY        <= 1'b0;
            DONE        <= 1'b0;
            IS_FACE     <= '0;
            TIMEOUT_ERR <= 1'b0;
            SRC_RD      <= 1'b0;
            SRC_ADDR    <= '0;
            AVM_CS      <= 1'b0;
            AVM_READ    <= 1'b0;
            AVM_WRITE   <= 1'b0;
            AVM_ADDR    <= '0;
        end else begin
            state       <= state_d;
            idx         <= idx_d;
            polls       <= polls_d;
            gap         <= gap_d;
            tmo         <= tmo_d;
            fresh       <= fresh_d;
            wdata_hold  <= wdata_d;
            BUSY        <= busy_d;
            DONE        <= done_d;
            IS_FACE     <= face_d;
            TIMEOUT_ERR <= terr_d;
            SRC_RD      <= src_rd_d;
            SRC_ADDR    <= src_addr_d;
            AVM_CS      <= cs_d;
            AVM_READ    <= read_d;
            AVM_WRITE   <= write_d;
            AVM_ADDR    <= addr_d;
        end
    end

endmodule
